bin2bcd_16b: RTL

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Sits directly downstream of the 8x8 multiplier. It captures the 16-bit product when the multiplier's end-of-operation strobe is wired to start. It produces five packed BCD digits for the display/readout stage, plus its own completion strobe and zero flag.

---
 rtl/bin2bcd_16b_if.sv | 23 ++
 rtl/bin2bcd_16b.sv | 114 +++++++++++
 2 files changed

// File: rtl/bin2bcd_16b_if.sv
// rtl/bin2bcd_16b_if.sv - request/result bundle for the bin2bcd_16b converter
interface bin2bcd_16b_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  fimConversao;
  logic                  Z;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, bin_in,
    input  bcd, busy, fimConversao, Z, blank
  );

  modport slave (
    input  start, bin_in,
    output bcd, busy, fimConversao, Z, blank
  );
endinterface

// File: rtl/bin2bcd_16b.sv
// rtl/bin2bcd_16b.sv - one-bit-per-clock double-dabble binary to BCD converter
// Optional leading-zero blank mask enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_16b #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic           clk,
  input  logic           rst,
  bin2bcd_16b_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state;
  logic [WIDTH-1:0]      bin_sr;
  logic [4*DIGITS-1:0]   bcd_work;
  logic [4*DIGITS-1:0]   next_work;
  logic [CW-1:0]         cnt;
  logic [4*DIGITS-1:0]   bcd_r;
  logic                  busy_r;
  logic                  fim_r;
  logic                  z_r;
  logic [3:0]            d;

  // Add-3 correction on every digit, then shift the binary MSB into the units LSB.
  always_comb begin
    next_work    = '0;
    d            = '0;
    next_work[0] = bin_sr[WIDTH-1];
    for (int i = 0; i < DIGITS; i++) begin
      d = bcd_work[4*i +: 4];
      if (d >= 4'd5) d = d + 4'd3;
      if (i == DIGITS - 1) next_work[4*i+1 +: 3] = d[2:0];
      else                 next_work[4*i+1 +: 4] = d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd_work <= '0;
      cnt      <= '0;
      bcd_r    <= '0;
      busy_r   <= 1'b0;
      fim_r    <= 1'b0;
      z_r      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          fim_r <= 1'b0;
          if (bus.start) begin
            bin_sr   <= bus.bin_in;
            bcd_work <= '0;
            cnt      <= CW'(WIDTH);
            busy_r   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_work <= next_work;
          bin_sr   <= {bin_sr[WIDTH-2:0], 1'b0};
          cnt      <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_r <= next_work;
            z_r   <= (next_work == '0);
            fim_r <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          fim_r  <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bcd          = bcd_r;
  assign bus.busy         = busy_r;
  assign bus.fimConversao = fim_r;
  assign bus.Z            = z_r;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_r;
  logic [DIGITS-1:0] blank_next;
  logic              lead;

  // Digit 0 is never blanked so a zero result still shows one "0".
  always_comb begin
    blank_next = '0;
    lead       = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead          = lead & (next_work[4*i +: 4] == 4'd0);
      blank_next[i] = lead;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_r <= '0;
    end else if (state == SHIFT && cnt == CW'(1)) begin
      blank_r <= blank_next;
    end
  end

  assign bus.blank = blank_r;
`else
  assign bus.blank = '0;
`endif
endmodule
